// File: rtl/mac_pkg.sv
// Shared constants and width helpers for the streaming multiply-accumulate engine.
package mac_pkg;

    localparam int MAC_LANES = 16;
    localparam int MAC_DW    = 8;
    localparam int MAC_ACC_W = 20;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Width of the per-beat lane sum: one full product plus carry growth.
    function automatic int mac_pw(input int lanes, input int dw);
        return 2 * dw + clog2(lanes);
    endfunction

    localparam int MAC_PW = mac_pw(MAC_LANES, MAC_DW);

endpackage

// File: rtl/mac_tree.sv
// Combinational balanced adder tree reducing the registered lane products to one beat sum.
module mac_tree
    import mac_pkg::*;
#(
    parameter int  LANES  = MAC_LANES,
    parameter int  DW     = MAC_DW,
    parameter bit  SIGNED = 1'b0,
    localparam int PW     = mac_pw(LANES, DW)
) (
    input  logic [LANES*2*DW-1:0] prod,
    output logic [PW-1:0]         t
);

    localparam int PD   = 2 * DW;
    localparam int LVL  = clog2(LANES);
    localparam int NPOW = 1 << LVL;

    // Level 0 holds the extended leaves (padded to a power of two); each level halves.
    genvar gi, gj;
    generate
        for (gi = 0; gi <= LVL; gi++) begin : g_lvl
            localparam int N = NPOW >> gi;
            logic [PW-1:0] v [N];
            for (gj = 0; gj < N; gj++) begin : g_node
                if (gi == 0) begin : g_leaf
                    if (gj >= LANES) begin : g_pad
                        assign v[gj] = '0;
                    end else if (SIGNED) begin : g_sext
                        assign v[gj] = PW'($signed(prod[gj*PD +: PD]));
                    end else begin : g_zext
                        assign v[gj] = PW'(prod[gj*PD +: PD]);
                    end
                end else begin : g_add
                    assign v[gj] = g_lvl[gi-1].v[2*gj] + g_lvl[gi-1].v[2*gj+1];
                end
            end
        end
    endgenerate

    assign t = g_lvl[LVL].v[0];

endmodule

// File: rtl/mac_stream.sv
// Pipelined lane-parallel multiply-accumulate with valid/ready input and a held output register.
module mac_stream
    import mac_pkg::*;
#(
    parameter int LANES  = MAC_LANES,
    parameter int DW     = MAC_DW,
    parameter int ACC_W  = MAC_ACC_W,
    parameter bit SIGNED = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_last,
    input  logic [LANES*DW-1:0] p,
    input  logic [LANES*DW-1:0] w,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    s,
    output logic                out_ovf
);

    localparam int PD = 2 * DW;
    localparam int PW = mac_pw(LANES, DW);

    logic                  stall;
    logic                  accept;
    logic [LANES*PD-1:0]   prod_in;

    logic [LANES*PD-1:0]   prod_q, prod_d;
    logic                  s1_last_q, s1_last_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic                  ovf_acc_q, ovf_acc_d;
    logic [ACC_W-1:0]      s_q, s_d;
    logic                  out_ovf_q, out_ovf_d;
    logic                  out_valid_q, out_valid_d;

    logic [PW-1:0]         t;
    logic [ACC_W:0]        t_ext;
    logic [ACC_W:0]        acc_ext;
    logic [ACC_W:0]        sum;
    logic                  step_ovf;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall && !reset;
    assign accept   = in_valid && in_ready;

    // Operands are widened to the full product width first so the multiply keeps every bit.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_mul
            logic [PD-1:0] pa;
            logic [PD-1:0] wa;
            if (SIGNED) begin : g_s
                assign pa = PD'($signed(p[gi*DW +: DW]));
                assign wa = PD'($signed(w[gi*DW +: DW]));
            end else begin : g_u
                assign pa = PD'(p[gi*DW +: DW]);
                assign wa = PD'(w[gi*DW +: DW]);
            end
            assign prod_in[gi*PD +: PD] = pa * wa;
        end
    endgenerate

    mac_tree #(
        .LANES  (LANES),
        .DW     (DW),
        .SIGNED (SIGNED)
    ) u_tree (
        .prod (prod_q),
        .t    (t)
    );

    // One guard bit above ACC_W makes the true sum exact, so overflow is a range test on it.
    generate
        if (SIGNED) begin : g_sacc
            assign t_ext    = (ACC_W+1)'($signed(t));
            assign acc_ext  = (ACC_W+1)'($signed(acc_q));
            assign sum      = acc_ext + t_ext;
            assign step_ovf = sum[ACC_W] ^ sum[ACC_W-1];
        end else begin : g_uacc
            assign t_ext    = (ACC_W+1)'(t);
            assign acc_ext  = (ACC_W+1)'(acc_q);
            assign sum      = acc_ext + t_ext;
            assign step_ovf = sum[ACC_W];
        end
    endgenerate

    always_comb begin
        prod_d      = prod_q;
        s1_last_d   = s1_last_q;
        s1_valid_d  = s1_valid_q;
        acc_d       = acc_q;
        ovf_acc_d   = ovf_acc_q;
        s_d         = s_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;

        // Everything advances together; a held output freezes the whole pipe.
        if (!stall) begin
            s1_valid_d  = accept;
            out_valid_d = 1'b0;
            if (accept) begin
                prod_d    = prod_in;
                s1_last_d = in_last;
            end
            if (s1_valid_q) begin
                if (s1_last_q) begin
                    s_d         = sum[ACC_W-1:0];
                    out_ovf_d   = ovf_acc_q | step_ovf;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    ovf_acc_d   = 1'b0;
                end else begin
                    acc_d     = sum[ACC_W-1:0];
                    ovf_acc_d = ovf_acc_q | step_ovf;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q      <= '0;
            s1_last_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            acc_q       <= '0;
            ovf_acc_q   <= 1'b0;
            s_q         <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            prod_q      <= prod_d;
            s1_last_q   <= s1_last_d;
            s1_valid_q  <= s1_valid_d;
            acc_q       <= acc_d;
            ovf_acc_q   <= ovf_acc_d;
            s_q         <= s_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mac_stream.sv
// Bench for mac_stream: an unsigned and a signed instance share one directed stimulus stream.
module tb_mac_stream;

    localparam int LANES = 16;
    localparam int DW    = 8;
    localparam int ACC_W = 20;
    localparam int VW    = LANES * DW;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_last;
    logic            out_ready;
    logic [VW-1:0]   p;
    logic [VW-1:0]   w;

    logic            in_ready_u, out_valid_u, ovf_u;
    logic [ACC_W-1:0] s_u;
    logic            in_ready_s, out_valid_s, ovf_s;
    logic [ACC_W-1:0] s_s;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mac_stream #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W), .SIGNED(1'b0)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_last(in_last), .p(p), .w(w), .out_valid(out_valid_u),
        .out_ready(out_ready), .s(s_u), .out_ovf(ovf_u)
    );

    mac_stream #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_last(in_last), .p(p), .w(w), .out_valid(out_valid_s),
        .out_ready(out_ready), .s(s_s), .out_ovf(ovf_s)
    );

    typedef struct {
        logic [ACC_W-1:0] s;
        logic             ovf;
        int               cyc;
    } res_t;

    res_t   q_u[$];
    res_t   q_s[$];
    longint acc_u, acc_sg, t_u, t_s;
    bit     flag_u, flag_s;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint dot(input logic [VW-1:0] pv, input logic [VW-1:0] wv, input bit sgn);
        longint acc;
        logic [7:0] a;
        logic [7:0] b;
        acc = 0;
        for (int k = 0; k < LANES; k++) begin
            a = pv[k*DW +: DW];
            b = wv[k*DW +: DW];
            if (sgn) acc += longint'($signed(a)) * longint'($signed(b));
            else     acc += longint'(a) * longint'(b);
        end
        return acc;
    endfunction

    function automatic bit out_of_range(input longint v, input bit sgn);
        if (sgn) return (v < -(longint'(1) << (ACC_W-1))) || (v > (longint'(1) << (ACC_W-1)) - 1);
        return (v < 0) || (v > (longint'(1) << ACC_W) - 1);
    endfunction

    function automatic longint wrap(input longint v, input bit sgn);
        longint m;
        m = v & ((longint'(1) << ACC_W) - 1);
        if (sgn && m >= (longint'(1) << (ACC_W-1))) m -= (longint'(1) << ACC_W);
        return m;
    endfunction

    // Reference: every accepted beat folds its dot product into an ACC_W-wide running sum.
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            acc_u = 0; acc_sg = 0; flag_u = 0; flag_s = 0;
            q_u.delete(); q_s.delete();
        end else begin
            if (out_valid_u && out_ready && q_u.size() > 0) void'(q_u.pop_front());
            if (out_valid_s && out_ready && q_s.size() > 0) void'(q_s.pop_front());
            if (in_valid && in_ready_u) begin
                t_u = acc_u + dot(p, w, 1'b0);
                flag_u |= out_of_range(t_u, 1'b0);
                acc_u = wrap(t_u, 1'b0);
                if (in_last) begin
                    q_u.push_back('{s: ACC_W'(acc_u), ovf: flag_u, cyc: cyc});
                    acc_u = 0; flag_u = 0;
                end
            end
            if (in_valid && in_ready_s) begin
                t_s = acc_sg + dot(p, w, 1'b1);
                flag_s |= out_of_range(t_s, 1'b1);
                acc_sg = wrap(t_s, 1'b1);
                if (in_last) begin
                    q_s.push_back('{s: ACC_W'(acc_sg), ovf: flag_s, cyc: cyc});
                    acc_sg = 0; flag_s = 0;
                end
            end
        end
    end

    // A result captured at edge c must be presented from edge c+1 until it is taken.
    task automatic cmp_out(input string tag, input logic ov, input logic [ACC_W-1:0] sv,
                           input logic ovfv, input res_t qq[$]);
        if (qq.size() == 0) begin
            chk({tag, " spurious_valid"}, 64'(ov), 64'(0));
        end else begin
            if (qq[0].cyc <= cyc - 1) chk({tag, " valid_due"}, 64'(ov), 64'(1));
            else                      chk({tag, " valid_early"}, 64'(ov), 64'(0));
            if (ov === 1'b1) begin
                chk({tag, " s"}, 64'(sv), 64'(qq[0].s));
                chk({tag, " ovf"}, 64'(ovfv), 64'(qq[0].ovf));
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("u in_ready", 64'(in_ready_u), 64'(!reset && !(out_valid_u && !out_ready)));
            chk("s in_ready", 64'(in_ready_s), 64'(!reset && !(out_valid_s && !out_ready)));
            cmp_out("u", out_valid_u, s_u, ovf_u, q_u);
            cmp_out("s", out_valid_s, s_s, ovf_s, q_s);
        end
    end

    function automatic logic [VW-1:0] lane0(input logic [7:0] b);
        return VW'(b);
    endfunction

    function automatic logic [VW-1:0] splat(input logic [7:0] b);
        return {LANES{b}};
    endfunction

    // Present one beat and wait (bounded) for the edge that captures it; returns #1 after that edge.
    task automatic send(input logic [VW-1:0] pv, input logic [VW-1:0] wv, input logic last);
        int n;
        p = pv; w = wv; in_last = last; in_valid = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!in_ready_u && n < 40);
        chk("send accepted", 64'(in_ready_u), 64'(1));
        #1;
        in_valid = 1'b0;
    endtask

    // One edge after capture the result must be on the output.
    task automatic expect_u(input string name, input logic [ACC_W-1:0] se, input logic oe);
        @(posedge clk);
        #1;
        chk({name, " valid"}, 64'(out_valid_u), 64'(1));
        chk({name, " s"}, 64'(s_u), 64'(se));
        chk({name, " ovf"}, 64'(ovf_u), 64'(oe));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        p = '0; w = '0; out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("reset out_valid", 64'(out_valid_u), 64'(0));
        chk("reset s", 64'(s_u), 64'(0));
        chk("reset ovf", 64'(ovf_u), 64'(0));
        chk("reset in_ready", 64'(in_ready_u), 64'(0));
        reset = 1'b0;
        #1;
        chk("post-reset in_ready", 64'(in_ready_u), 64'(1));

        send(lane0(8'h03), lane0(8'h05), 1'b1);
        expect_u("lane0", 20'h0000F, 1'b0);

        send(splat(8'hFF), splat(8'hFF), 1'b1);
        expect_u("fullscale", 20'hFE010, 1'b0);

        send(splat(8'hFF), splat(8'hFF), 1'b0);
        send(splat(8'hFF), splat(8'hFF), 1'b1);
        expect_u("wrap", 20'hFC020, 1'b1);

        send(splat(8'h01), splat(8'h01), 1'b1);
        expect_u("after wrap", 20'h00010, 1'b0);

        send(splat(8'h80), splat(8'h7F), 1'b1);
        @(posedge clk);
        #1;
        chk("signed s", 64'(s_s), 64'(20'hC0800));
        chk("signed ovf", 64'(ovf_s), 64'(0));
        chk("unsigned 80x7F s", 64'(s_u), 64'(20'h3F800));
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        fork
            begin
                send(lane0(8'd1), lane0(8'd1), 1'b1);
                send(lane0(8'd2), lane0(8'd1), 1'b1);
                send(lane0(8'd3), lane0(8'd1), 1'b1);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                chk("held in_ready", 64'(in_ready_u), 64'(0));
                chk("held valid", 64'(out_valid_u), 64'(1));
                chk("held s", 64'(s_u), 64'(1));
                out_ready = 1'b1;
            end
        join
        chk("bp second s", 64'(s_u), 64'(2));
        @(posedge clk);
        #1;
        chk("bp third s", 64'(s_u), 64'(3));
        repeat (2) @(posedge clk);
        #1;

        send(splat(8'hFF), splat(8'hFF), 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(splat(8'h02), splat(8'h02), 1'b1);
        expect_u("after reset", 20'h00040, 1'b0);
        chk("after reset signed s", 64'(s_s), 64'(20'h00040));

        repeat (5) @(posedge clk);
        #1;
        chk("drain u", 64'(q_u.size()), 64'(0));
        chk("drain s", 64'(q_s.size()), 64'(0));
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
